// File: rtl/alu_cmd_sequencer.sv
// Command sequencer: buffers ALU commands in a small FIFO, issues them one at a time
// to an external combinational ALU, and holds each result until the consumer takes it.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_a,
    input  logic [5:0]  cmd_b,
    input  logic [1:0]  cmd_op,
    output logic [5:0]  alu_a,
    output logic [5:0]  alu_b,
    output logic [1:0]  alu_sel,
    input  logic [11:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [11:0] rsp_data,
    output logic [1:0]  rsp_op,
    output logic        rsp_flag,
    output logic        rsp_zero
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [13:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] avail_count;
    logic          push;
    logic          push_d;
    logic          pop;
    logic          capture;
    logic          release_rsp;
    logic          avail_nz;
    logic          next_flag;
    logic [13:0]   head;

    assign push     = cmd_valid && cmd_ready;
    assign avail_nz = (avail_count != '0);
    assign head     = fifo_mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    // A written entry becomes visible to the read side one cycle after its write,
    // so avail_count trails count on pushes but tracks pops immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            avail_count <= '0;
            push_d      <= 1'b0;
            cmd_ready   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count       <= count_next;
            avail_count <= avail_count + CW'(push_d) - CW'(pop);
            push_d      <= push;
            cmd_ready   <= (count_next < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            IDLE: begin
                if (avail_nz) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    release_rsp = 1'b1;
                    if (avail_nz) begin
                        pop        = 1'b1;
                        state_next = EXEC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Carry and borrow come from the registered operands, not from the ALU result,
    // because the ALU truncates add/sub to six bits.
    always_comb begin
        next_flag = 1'b0;
        case (alu_sel)
            OP_ADD:  next_flag = (({1'b0, alu_a} + {1'b0, alu_b}) > 7'd63);
            OP_SUB:  next_flag = (alu_a < alu_b);
            default: next_flag = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else if (pop) begin
            {alu_sel, alu_a, alu_b} <= head;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_op    <= '0;
            rsp_flag  <= 1'b0;
            rsp_zero  <= 1'b1;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result;
            rsp_op    <= alu_sel;
            rsp_flag  <= next_flag;
            rsp_zero  <= (alu_result == 12'd0);
        end else if (release_rsp) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural ALU attached.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_a = '0;
    logic [5:0]  cmd_b = '0;
    logic [1:0]  cmd_op = '0;
    logic [5:0]  alu_a;
    logic [5:0]  alu_b;
    logic [1:0]  alu_sel;
    logic [11:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [11:0] rsp_data;
    logic [1:0]  rsp_op;
    logic        rsp_flag;
    logic        rsp_zero;

    int tests_run = 0;
    int tests_failed = 0;

    logic [1:0] v_op [8];
    logic [5:0] v_a  [8];
    logic [5:0] v_b  [8];

    function automatic logic [11:0] model_result(input logic [1:0] op, input logic [5:0] a,
                                                 input logic [5:0] b);
        logic [5:0] t;
        case (op)
            2'b00:   begin t = a + b; return {6'b0, t}; end
            2'b01:   begin t = a - b; return {6'b0, t}; end
            2'b10:   return {6'b0, a} * {6'b0, b};
            default: return {6'b0, a & b};
        endcase
    endfunction

    function automatic logic model_flag(input logic [1:0] op, input logic [5:0] a,
                                        input logic [5:0] b);
        int s;
        s = int'(a) + int'(b);
        if (op == 2'b00) return (s > 63);
        if (op == 2'b01) return (int'(a) < int'(b));
        return 1'b0;
    endfunction

    assign alu_result = model_result(alu_sel, alu_a, alu_b);

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_op     (rsp_op),
        .rsp_flag   (rsp_flag),
        .rsp_zero   (rsp_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        tests_run++; if (rsp_data !== 12'h000) begin tests_failed++; $display("[TB] FAIL reset_rsp_data: got %h expected 000", rsp_data); end
        tests_run++; if (rsp_op !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_rsp_op: got %b expected 00", rsp_op); end
        tests_run++; if (rsp_flag !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_flag: got %b expected 0", rsp_flag); end
        tests_run++; if (rsp_zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_rsp_zero: got %b expected 1", rsp_zero); end
        tests_run++; if ({alu_sel, alu_a, alu_b} !== 14'h0) begin tests_failed++; $display("[TB] FAIL reset_alu_regs: got %h expected 0000", {alu_sel, alu_a, alu_b}); end
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_single(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b,
                               input logic [11:0] exp_data, input logic exp_flag,
                               input logic exp_zero, input string name);
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s_ready: got %b expected 1", name, cmd_ready); end
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s_early: got rsp_valid %b expected 0", name, rsp_valid); end
        tick();
        tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s_latency: got rsp_valid %b expected 1", name, rsp_valid); end
        tests_run++; if (rsp_data !== exp_data) begin tests_failed++; $display("[TB] FAIL %s_data: got %h expected %h", name, rsp_data, exp_data); end
        tests_run++; if (rsp_flag !== exp_flag) begin tests_failed++; $display("[TB] FAIL %s_flag: got %b expected %b", name, rsp_flag, exp_flag); end
        tests_run++; if (rsp_zero !== exp_zero) begin tests_failed++; $display("[TB] FAIL %s_zero: got %b expected %b", name, rsp_zero, exp_zero); end
        tests_run++; if (rsp_op !== op) begin tests_failed++; $display("[TB] FAIL %s_op: got %b expected %b", name, rsp_op, op); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s_release: got rsp_valid %b expected 0", name, rsp_valid); end
    endtask

    task automatic fill_fifo(output int accepted);
        accepted = 0;
        for (int c = 0; c < 9; c++) begin
            cmd_op = v_op[accepted % 8]; cmd_a = v_a[accepted % 8]; cmd_b = v_b[accepted % 8];
            cmd_valid = 1'b1;
            if (cmd_ready === 1'b1) accepted++;
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int accepted;
        int idx;
        logic [11:0] held;
        logic [11:0] exp;
        logic checked_ready;
        for (int i = 0; i < 8; i++) begin
            v_op[i] = 2'(i);
            v_a[i]  = 6'(7 * i + 5);
            v_b[i]  = 6'(3 * i + 2);
        end
        fill_fifo(accepted);
        tests_run++; if (accepted != 5) begin tests_failed++; $display("[TB] FAIL bp_accepts: got %0d expected 5", accepted); end
        tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_cmd_ready: got %b expected 0", cmd_ready); end
        exp = model_result(v_op[0], v_a[0], v_b[0]);
        tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== exp) begin tests_failed++; $display("[TB] FAIL bp_head_rsp: got valid %b data %h expected 1 %h", rsp_valid, rsp_data, exp); end
        held = rsp_data;
        cmd_valid = 1'b1;
        tick(); tick(); tick();
        cmd_valid = 1'b0;
        tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_stable: got valid %b data %h ready %b expected 1 %h 0", rsp_valid, rsp_data, cmd_ready, held); end
        rsp_ready = 1'b1;
        idx = 0;
        checked_ready = 1'b0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            if (rsp_valid === 1'b1) begin
                exp = model_result(v_op[idx], v_a[idx], v_b[idx]);
                tests_run++; if (rsp_data !== exp || rsp_op !== v_op[idx] || rsp_flag !== model_flag(v_op[idx], v_a[idx], v_b[idx])) begin tests_failed++; $display("[TB] FAIL bp_drain_%0d: got data %h op %b flag %b expected %h %b %b", idx, rsp_data, rsp_op, rsp_flag, exp, v_op[idx], model_flag(v_op[idx], v_a[idx], v_b[idx])); end
                idx++;
            end
            tick();
            if (idx == 1 && !checked_ready) begin
                checked_ready = 1'b1;
                tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_ready_after_pop: got %b expected 1", cmd_ready); end
            end
        end
        rsp_ready = 1'b0;
        tests_run++; if (idx != 5) begin tests_failed++; $display("[TB] FAIL bp_drain_count: got %0d expected 5", idx); end
        tick();
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_no_extra: got rsp_valid %b expected 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] b_op [6];
        logic [5:0] b_a  [6];
        logic [5:0] b_b  [6];
        logic [11:0] exp;
        int sent;
        int got;
        int last;
        for (int i = 0; i < 6; i++) begin
            b_op[i] = 2'((i + 1) % 4);
            b_a[i]  = 6'(11 * i + 1);
            b_b[i]  = 6'(5 * i + 3);
        end
        sent = 0; got = 0; last = -1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && got < 6; c++) begin
            if (rsp_valid === 1'b1) begin
                exp = model_result(b_op[got], b_a[got], b_b[got]);
                tests_run++; if (rsp_data !== exp || rsp_op !== b_op[got]) begin tests_failed++; $display("[TB] FAIL b2b_rsp_%0d: got data %h op %b expected %h %b", got, rsp_data, rsp_op, exp, b_op[got]); end
                if (got > 0) begin
                    tests_run++; if (c - last != 2) begin tests_failed++; $display("[TB] FAIL b2b_gap_%0d: got %0d cycles expected 2", got, c - last); end
                end
                last = c;
                got++;
            end
            if (sent < 6) begin
                cmd_op = b_op[sent]; cmd_a = b_a[sent]; cmd_b = b_b[sent];
                cmd_valid = 1'b1;
                if (cmd_ready === 1'b1) sent++;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        tests_run++; if (got != 6) begin tests_failed++; $display("[TB] FAIL b2b_count: got %0d expected 6", got); end
        tick(); tick();
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_no_dup: got rsp_valid %b expected 0", rsp_valid); end
    endtask

    task automatic test_reset_mid_exec();
        int accepted;
        int stale;
        fill_fifo(accepted);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests_run++; if (rsp_valid !== 1'b0 || rsp_data === 12'h000) begin tests_failed++; $display("[TB] FAIL rst_pre_exec: got valid %b data %h expected 0 nonzero", rsp_valid, rsp_data); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (rsp_valid !== 1'b0 || rsp_data !== 12'h000 || rsp_zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_async_rsp: got valid %b data %h zero %b expected 0 000 1", rsp_valid, rsp_data, rsp_zero); end
        tests_run++; if ({alu_sel, alu_a, alu_b} !== 14'h0) begin tests_failed++; $display("[TB] FAIL rst_async_alu: got %h expected 0000", {alu_sel, alu_a, alu_b}); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
        rsp_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid !== 1'b0) stale++;
            tick();
        end
        rsp_ready = 1'b0;
        tests_run++; if (stale != 0) begin tests_failed++; $display("[TB] FAIL rst_stale: got %0d stale cycles expected 0", stale); end
    endtask

    initial begin
        test_reset();
        test_single(2'b00, 6'd9,   6'd5,   12'h00E, 1'b0, 1'b0, "add_9_5");
        test_single(2'b01, 6'd5,   6'd9,   12'h03C, 1'b1, 1'b0, "sub_5_9");
        test_single(2'b00, 6'd63,  6'd1,   12'h000, 1'b1, 1'b1, "add_63_1");
        test_single(2'b10, 6'd63,  6'd63,  12'hF81, 1'b0, 1'b0, "mul_63_63");
        test_single(2'b11, 6'h2A,  6'h0F,  12'h00A, 1'b0, 1'b0, "and_2a_0f");
        test_backpressure();
        test_back_to_back();
        test_reset_mid_exec();
        test_single(2'b01, 6'd40,  6'd12,  12'h01C, 1'b0, 1'b0, "sub_after_reset");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter: DEPTH, default 4, command FIFO entries; SHALL be a power of two and at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  command FIFO can accept.
REQ-006 cmd_a, cmd_b  input  6 each  operands.
REQ-007 cmd_op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 and.
REQ-008 alu_a, alu_b  output  6 each  registered operands driven to the ALU.
REQ-009 alu_sel  output  2  registered opcode driven to the ALU.
REQ-010 alu_result  input  12  combinational ALU result, zero-extended for add/sub/and.
REQ-011 rsp_valid  output  1  response held.
REQ-012 rsp_ready  input  1  consumer accepts the response.
REQ-013 rsp_data  output  12  captured result.
REQ-014 rsp_op  output  2  opcode of the response.
REQ-015 rsp_flag  output  1  add carry-out or sub borrow-out; 0 for mul and and.
REQ-016 rsp_zero  output  1  rsp_data == 0.

Function
REQ-017 Command accepted on a rising edge where cmd_valid && cmd_ready; {op,a,b} written at FIFO tail.
REQ-018 cmd_ready SHALL be 1 exactly when FIFO occupancy < DEPTH; it SHALL be registered and SHALL NOT depend on cmd_valid or rsp_ready.
REQ-019 Occupancy counter range 0..DEPTH; pointers wrap modulo DEPTH; a push and a pop in the same cycle leave the count unchanged.
REQ-020 FSM states: IDLE, EXEC, RESP.
REQ-021 IDLE: if FIFO non-empty, pop the head, load alu_a/alu_b/alu_sel, go to EXEC; otherwise stay in IDLE.
REQ-022 EXEC: on the next edge capture alu_result into rsp_data and compute rsp_flag, rsp_zero and rsp_op; set rsp_valid; go to RESP.
REQ-023 RESP: hold all rsp_* outputs stable while rsp_valid && !rsp_ready.
REQ-024 RESP on handshake, FIFO non-empty: clear rsp_valid, pop, load the alu_* registers, go to EXEC.
REQ-025 RESP on handshake, FIFO empty: clear rsp_valid and go to IDLE.
REQ-026 Latency: command accepted at edge N into an empty idle block gives rsp_valid = 1 after edge N+3; sustained throughput is one command per 2 cycles.
REQ-027 Add: rsp_flag = carry bit of (alu_a + alu_b) computed at 7 bits from the registered operands.
REQ-028 Sub: rsp_flag = 1 when alu_a < alu_b (unsigned).
REQ-029 alu_a, alu_b and alu_sel SHALL hold their value outside loads; they SHALL NOT change during EXEC.
REQ-030 Commands SHALL complete in acceptance order; none dropped or duplicated.
REQ-031 Total held commands SHALL be at most DEPTH+1: DEPTH in the FIFO plus one in EXEC or RESP.

Reset
REQ-032 rst_n low SHALL immediately (asynchronously) force these values:
- FSM = IDLE
- occupancy = 0, pointers = 0
- cmd_ready = 1 from the first edge after deassertion
- rsp_valid = 0, rsp_data = 0, rsp_op = 0, rsp_flag = 0, rsp_zero = 1
- alu_a = 0, alu_b = 0, alu_sel = 0
REQ-033 Reset mid-operation SHALL discard all FIFO contents and any in-flight or held response; no response SHALL appear after deassertion until a new command is accepted.
REQ-034 FIFO storage contents need no reset.

Verification
REQ-035 Add a=9, b=5 -> rsp_data=0x00E, flag=0, zero=0, rsp_valid exactly 3 edges after acceptance.
REQ-036 Sub a=5, b=9 -> rsp_data=0x03C, flag=1; add a=63, b=1 -> rsp_data=0x000, flag=1, zero=1.
REQ-037 Mul a=63, b=63 -> rsp_data=0xF81, flag=0; and a=0x2A, b=0x0F -> rsp_data=0x00A.
REQ-038 rsp_ready held 0 with continuous cmd_valid -> exactly DEPTH+1 (5) accepts, then cmd_ready=0 and rsp_* stable.
- Then rsp_ready=1 -> all 5 responses drain in order.
- cmd_ready rises the edge after the first FIFO pop.
REQ-039 Back-to-back commands with rsp_ready=1 -> one response every 2 cycles, order preserved, no drops or duplicates.
REQ-040 rst_n pulsed low while in EXEC with 3 commands queued:
- rsp_valid=0 immediately, cmd_ready=1 after deassertion.
- No stale response appears afterwards.
